// File: rtl/flash_slave_pkg.sv
// Shared definitions for the SPI NOR-flash responder.
// Contents: supported opcodes, per-frame command state, status register bit indices.
package flash_slave_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    localparam int SR_BUSY = 0;
    localparam int SR_WEL  = 1;

endpackage

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave bit engine, oversampled on the system clock.
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   spi_clk/cs/mosi     raw SPI inputs (asynchronous to i_clk)
//   spi_miso            serial output, 0 whenever not selected
//   selected            synchronized CS is low
//   cs_rise             one-cycle pulse when synchronized CS goes high
//   bit_cnt             bits received in the current byte
//   rx_valid / rx_byte  pulse + byte on the rising SCLK edge that completes a byte
//   tx_req              same pulse; the owner must present tx_byte before the next falling edge
//   tx_byte             next byte to shift out, MSB first
module spi_slave_phy (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic       selected,
    output logic       cs_rise,
    output logic [2:0] bit_cnt,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       tx_req
);

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_d, cs_d;
    logic       sclk_rise, sclk_fall;
    logic [6:0] rx_sh;
    logic [6:0] tx_sh;      // bits still to be sent after the one on spi_miso
    logic       load_pend;  // last rising edge completed a byte

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign selected  = ~cs_sync[1];
    assign cs_rise   = cs_sync[1] & ~cs_d;
    assign rx_valid  = selected & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sh, mosi_sync[1]};
    assign tx_req    = rx_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst || !selected) begin
            bit_cnt   <= 3'd0;
            rx_sh     <= 7'd0;
            tx_sh     <= 7'd0;
            spi_miso  <= 1'b0;
            load_pend <= 1'b0;
        end else begin
            if (sclk_rise) begin
                rx_sh   <= {rx_sh[5:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    load_pend <= 1'b1;
            end
            if (sclk_fall) begin
                if (load_pend) begin
                    spi_miso  <= tx_byte[7];
                    tx_sh     <= tx_byte[6:0];
                    load_pend <= 1'b0;
                end else begin
                    spi_miso <= tx_sh[6];
                    tx_sh    <= {tx_sh[5:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_slave.sv
// SPI NOR-flash responder serving a small internal byte memory.
// Commands: WREN, WRDI, RDSR, RDID, READ, PP, SE. Mode 0, MSB first.
// Ports:
//   i_clk, i_rst           system clock (>= 8x SCLK), synchronous active-high reset
//   i_spi_clk/cs/mosi      SPI inputs from the master
//   o_spi_miso             SPI output, 0 when not selected
//   o_busy, o_wel          status WIP and write-enable-latch bits
// Reset starts a full-array fill with 0xFF; o_busy stays high until it ends.
module spi_flash_slave
    import flash_slave_pkg::*;
#(
    parameter int          P_MEM_AW      = 10,
    parameter int          P_BUSY_CYCLES = 64,
    parameter logic [23:0] P_JEDEC_ID    = 24'hEF4017
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_spi_clk,
    input  logic i_spi_cs,
    input  logic i_spi_mosi,
    output logic o_spi_miso,
    output logic o_busy,
    output logic o_wel
);

    localparam int RB = (P_MEM_AW < 12) ? P_MEM_AW : 12;
    localparam logic [P_MEM_AW-1:0] RG_MASK = P_MEM_AW'((1 << RB) - 1);
    localparam logic [P_MEM_AW-1:0] PG_MASK = P_MEM_AW'(255);
    localparam int BW = $clog2(P_BUSY_CYCLES + 1);

    logic                selected, cs_rise, rx_valid, tx_req;
    logic [2:0]          bit_cnt;
    logic [7:0]          rx_byte, tx_byte;
    state_t              state_q, state_d;
    logic [7:0]          opcode, byte_cnt, mem_rd;
    logic [P_MEM_AW-1:0] addr, addr_shift, addr_inc, addr_pg, rd_addr;
    logic [P_MEM_AW-1:0] er_addr, er_last;
    logic                pp_wrote, wel, er_active, busy, pp_we, se_go, pp_done;
    logic [BW-1:0]       busy_cnt;
    logic [7:0]          mem [2**P_MEM_AW];

    spi_slave_phy u_phy (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .spi_clk  (i_spi_clk),
        .spi_cs   (i_spi_cs),
        .spi_mosi (i_spi_mosi),
        .tx_byte  (tx_byte),
        .spi_miso (o_spi_miso),
        .selected (selected),
        .cs_rise  (cs_rise),
        .bit_cnt  (bit_cnt),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_req   (tx_req)
    );

    assign busy   = er_active | (busy_cnt != '0);
    assign o_busy = busy;
    assign o_wel  = wel;

    // Only low address bits matter; upper SPI address bits fall off the top.
    assign addr_shift = P_MEM_AW'({addr, rx_byte});
    assign addr_inc   = addr + P_MEM_AW'(1);
    assign addr_pg    = (addr & ~PG_MASK) | (addr_inc & PG_MASK);
    // The last address byte and each READ data byte both prefetch the next TX byte.
    assign rd_addr    = (state_q == ST_ADDR) ? addr_shift : addr_inc;
    assign pp_we      = rx_valid && state_q == ST_DATA && opcode == OP_PP;
    // Frame-end decisions see the frame's last values: the clear happens at this edge.
    assign se_go      = cs_rise && state_q == ST_DATA && opcode == OP_SE &&
                        byte_cnt == 8'd4 && bit_cnt == 3'd0;
    assign pp_done    = cs_rise && state_q == ST_DATA && opcode == OP_PP && pp_wrote;

    always_comb begin
        state_d = state_q;
        if (!selected) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: if (rx_valid) begin
                    if (busy && rx_byte != OP_RDSR)
                        state_d = ST_IGNORE;
                    else begin
                        case (rx_byte)
                            OP_RDSR, OP_RDID, OP_WREN, OP_WRDI: state_d = ST_DATA;
                            OP_READ:                            state_d = ST_ADDR;
                            OP_PP, OP_SE: state_d = wel ? ST_ADDR : ST_IGNORE;
                            default:                            state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: if (rx_valid && byte_cnt == 8'd3) state_d = ST_DATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        if (state_q == ST_DATA) begin
            case (opcode)
                OP_RDSR: begin
                    tx_byte[SR_WEL]  = wel;
                    tx_byte[SR_BUSY] = busy;
                end
                OP_RDID: begin
                    case (byte_cnt)
                        8'd1:    tx_byte = P_JEDEC_ID[23:16];
                        8'd2:    tx_byte = P_JEDEC_ID[15:8];
                        8'd3:    tx_byte = P_JEDEC_ID[7:0];
                        default: tx_byte = 8'h00;
                    endcase
                end
                OP_READ: tx_byte = mem_rd;
                default: tx_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            opcode    <= 8'h00;
            addr      <= '0;
            byte_cnt  <= 8'd0;
            pp_wrote  <= 1'b0;
            wel       <= 1'b0;
            busy_cnt  <= '0;
            er_active <= 1'b1;
            er_addr   <= '0;
            er_last   <= '1;
        end else begin
            state_q <= state_d;

            if (!selected) begin
                opcode   <= 8'h00;
                addr     <= '0;
                byte_cnt <= 8'd0;
                pp_wrote <= 1'b0;
            end else if (rx_valid) begin
                if (byte_cnt != 8'hFF)
                    byte_cnt <= byte_cnt + 8'd1;
                case (state_q)
                    ST_CMD:  opcode <= rx_byte;
                    ST_ADDR: addr   <= addr_shift;
                    ST_DATA: begin
                        if (opcode == OP_READ)
                            addr <= addr_inc;
                        else if (opcode == OP_PP) begin
                            addr     <= addr_pg;
                            pp_wrote <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (cs_rise && state_q == ST_DATA) begin
                if (opcode == OP_WREN) wel <= 1'b1;
                if (opcode == OP_WRDI) wel <= 1'b0;
            end

            if (pp_done) begin
                wel      <= 1'b0;
                busy_cnt <= BW'(P_BUSY_CYCLES);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
            end

            if (se_go) begin
                er_active <= 1'b1;
                er_addr   <= addr & ~RG_MASK;
                er_last   <= addr | RG_MASK;
            end else if (er_active) begin
                if (er_addr == er_last) begin
                    er_active <= 1'b0;
                    wel       <= 1'b0;
                end else begin
                    er_addr <= er_addr + P_MEM_AW'(1);
                end
            end
        end
    end

    // Erase and program never overlap: a program is only accepted while not busy.
    always_ff @(posedge i_clk) begin
        if (er_active)
            mem[er_addr] <= 8'hFF;
        else if (pp_we)
            mem[addr] <= mem[addr] & rx_byte;
        if (tx_req)
            mem_rd <= mem[rd_addr];
    end

endmodule
